// File: rtl/stream_stats.sv
// rtl/stream_stats.sv - per-frame max/min/count statistics over a gated sample stream
// Optional sum output enabled by defining STREAM_STATS_SUM_EN.
module stream_stats #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] min,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             cnt_sat
`ifdef STREAM_STATS_SUM_EN
    ,
    output logic [WIDTH+CNT_W-1:0] sum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_max;
    logic [WIDTH-1:0] acc_min;
    logic [CNT_W-1:0] acc_count;
    logic             acc_first;
    logic             acc_sat;
    logic             enter_run;
    logic             take;
    logic             finish;
    logic             in_gt;
    logic             in_lt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (!start) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    // A frame (re)starts from IDLE or DONE; the sample of that cycle belongs to the new frame.
    assign enter_run = start && (state_q != RUN);
    assign take      = start && in_valid;
    assign finish    = (state_q == RUN) && !start;
    assign acc_sat   = (acc_count == CNT_MAX);

    always_comb begin
        if (SIGNED != 0) begin
            in_gt = $signed(in) > $signed(acc_max);
            in_lt = $signed(in) < $signed(acc_min);
        end else begin
            in_gt = in > acc_max;
            in_lt = in < acc_min;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_max   <= '0;
            acc_min   <= '0;
            acc_count <= '0;
            acc_first <= 1'b0;
        end else if (enter_run) begin
            acc_max   <= take ? in : '0;
            acc_min   <= take ? in : '0;
            acc_count <= take ? CNT_W'(1) : '0;
            acc_first <= !take;
        end else if ((state_q == RUN) && take) begin
            if (acc_first || in_gt) acc_max <= in;
            if (acc_first || in_lt) acc_min <= in;
            if (!acc_sat) acc_count <= acc_count + CNT_W'(1);
            acc_first <= 1'b0;
        end
    end

`ifdef STREAM_STATS_SUM_EN
    logic [WIDTH+CNT_W-1:0] acc_sum;
    logic [WIDTH+CNT_W-1:0] in_ext;

    always_comb begin
        if (SIGNED != 0) begin
            in_ext = {{CNT_W{in[WIDTH-1]}}, in};
        end else begin
            in_ext = {{CNT_W{1'b0}}, in};
        end
    end

    // Sum freezes together with the counter, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum <= '0;
        end else if (enter_run) begin
            acc_sum <= take ? in_ext : '0;
        end else if ((state_q == RUN) && take && !acc_sat) begin
            acc_sum <= acc_sum + in_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (finish) begin
            sum <= acc_sum;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            max     <= '0;
            min     <= '0;
            count   <= '0;
            empty   <= 1'b1;
            cnt_sat <= 1'b0;
        end else begin
            done <= (state_d == DONE);
            if (finish) begin
                max     <= acc_max;
                min     <= acc_min;
                count   <= acc_count;
                empty   <= (acc_count == '0);
                cnt_sat <= acc_sat;
            end
        end
    end

endmodule
